// File: rtl/spi_sclk_engine_if.sv
// Request/status bundle between an SPI frame requester (master) and the
// SCLK/CS engine (slave).
interface spi_sclk_engine_if #(
   parameter int DIV_WIDTH = 16,
   parameter int MAX_BITS  = 32
);
   localparam int NB_W = $clog2(MAX_BITS + 1);

   logic                 start_i;
   logic                 abort_i;
   logic [DIV_WIDTH-1:0] div_i;
   logic                 cpol_i;
   logic                 cpha_i;
   logic [NB_W-1:0]      nbits_i;
   logic                 cs_n_o;
   logic                 sclk_o;
   logic                 sample_stb_o;
   logic                 shift_stb_o;
   logic                 busy_o;
   logic                 done_o;
   logic [NB_W-1:0]      bit_idx_o;

   modport master (
      output start_i, abort_i, div_i, cpol_i, cpha_i, nbits_i,
      input  cs_n_o, sclk_o, sample_stb_o, shift_stb_o, busy_o, done_o, bit_idx_o
   );

   modport slave (
      input  start_i, abort_i, div_i, cpol_i, cpha_i, nbits_i,
      output cs_n_o, sclk_o, sample_stb_o, shift_stb_o, busy_o, done_o, bit_idx_o
   );
endinterface

// File: rtl/spi_sclk_engine.sv
// SPI clock/frame engine: owns chip select, generates SCLK in all four
// CPOL/CPHA modes and emits one-cycle sample/shift strobes for a shift register.
module spi_sclk_engine #(
   parameter int DIV_WIDTH = 16,
   parameter int MAX_BITS  = 32,
   parameter int CS_SETUP  = 2,
   parameter int CS_HOLD   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_sclk_engine_if.slave bus
);
   localparam int NB_W    = $clog2(MAX_BITS + 1);
   localparam int EDG_W   = NB_W + 1;
   localparam int GAP_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int GAP_W   = $clog2(GAP_MAX) + 1;

   localparam logic [GAP_W-1:0] SETUP_LAST = GAP_W'(CS_SETUP - 1);
   localparam logic [GAP_W-1:0] HOLD_LAST  = GAP_W'(CS_HOLD - 1);
   localparam logic [NB_W-1:0]  NBITS_MAX  = NB_W'(MAX_BITS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_RUN   = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [DIV_WIDTH-1:0] r_div;
   logic [DIV_WIDTH-1:0] w_div_nxt;
   logic                 r_cpol;
   logic                 w_cpol_nxt;
   logic                 r_cpha;
   logic                 w_cpha_nxt;
   logic [NB_W-1:0]      r_nbits;
   logic [NB_W-1:0]      w_nbits_nxt;
   logic [DIV_WIDTH-1:0] r_half_cnt;
   logic [DIV_WIDTH-1:0] w_half_cnt_nxt;
   logic [GAP_W-1:0]     r_gap_cnt;
   logic [GAP_W-1:0]     w_gap_cnt_nxt;
   logic [EDG_W-1:0]     r_edge_cnt;
   logic [EDG_W-1:0]     w_edge_cnt_nxt;
   logic                 r_cs_n;
   logic                 w_cs_n_nxt;
   logic                 r_sclk;
   logic                 w_sclk_nxt;
   logic                 r_sample_stb;
   logic                 w_sample_stb_nxt;
   logic                 r_shift_stb;
   logic                 w_shift_stb_nxt;
   logic                 r_busy;
   logic                 w_busy_nxt;
   logic                 r_done;
   logic                 w_done_nxt;
   logic [NB_W-1:0]      r_bit_idx;
   logic [NB_W-1:0]      w_bit_idx_nxt;

   logic [EDG_W-1:0]     w_edge_inc;
   logic                 w_leading;
   logic                 w_last_edge;
   logic                 w_start_ok;
   logic [NB_W-1:0]      w_nbits_clamp;

   assign w_edge_inc    = r_edge_cnt + EDG_W'(1);
   assign w_leading     = w_edge_inc[0];
   assign w_last_edge   = (w_edge_inc == {r_nbits, 1'b0});
   // A start landing in the done cycle is dropped, not deferred.
   assign w_start_ok    = bus.start_i && !bus.abort_i && !r_done;
   assign w_nbits_clamp = (bus.nbits_i > NBITS_MAX) ? NBITS_MAX : bus.nbits_i;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, counter and output decode
   always_comb begin
      w_state_nxt      = r_state;
      w_div_nxt        = r_div;
      w_cpol_nxt       = r_cpol;
      w_cpha_nxt       = r_cpha;
      w_nbits_nxt      = r_nbits;
      w_half_cnt_nxt   = r_half_cnt;
      w_gap_cnt_nxt    = r_gap_cnt;
      w_edge_cnt_nxt   = r_edge_cnt;
      w_cs_n_nxt       = r_cs_n;
      w_sclk_nxt       = r_sclk;
      w_busy_nxt       = r_busy;
      w_bit_idx_nxt    = r_bit_idx;
      w_sample_stb_nxt = 1'b0;
      w_shift_stb_nxt  = 1'b0;
      w_done_nxt       = 1'b0;

      if ((r_state != ST_IDLE) && bus.abort_i) begin
         w_state_nxt = ST_IDLE;
         w_cs_n_nxt  = 1'b1;
         w_sclk_nxt  = r_cpol;
         w_busy_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_cs_n_nxt = 1'b1;
               w_busy_nxt = 1'b0;
               w_sclk_nxt = r_cpol;
               if (w_start_ok) begin
                  w_state_nxt    = ST_SETUP;
                  w_div_nxt      = bus.div_i;
                  w_cpol_nxt     = bus.cpol_i;
                  w_cpha_nxt     = bus.cpha_i;
                  w_nbits_nxt    = w_nbits_clamp;
                  w_half_cnt_nxt = {DIV_WIDTH{1'b0}};
                  w_gap_cnt_nxt  = {GAP_W{1'b0}};
                  w_edge_cnt_nxt = {EDG_W{1'b0}};
                  w_bit_idx_nxt  = {NB_W{1'b0}};
                  w_cs_n_nxt     = 1'b0;
                  w_busy_nxt     = 1'b1;
                  w_sclk_nxt     = bus.cpol_i;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_SETUP: begin
               if (r_gap_cnt == SETUP_LAST) begin
                  w_gap_cnt_nxt  = {GAP_W{1'b0}};
                  w_half_cnt_nxt = {DIV_WIDTH{1'b0}};
                  if (r_nbits == {NB_W{1'b0}}) begin
                     w_state_nxt = ST_HOLD;
                  end else begin
                     w_state_nxt = ST_RUN;
                  end
               end else begin
                  w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
               end
            end
            ST_RUN: begin
               if (r_half_cnt == r_div) begin
                  w_half_cnt_nxt = {DIV_WIDTH{1'b0}};
                  w_sclk_nxt     = ~r_sclk;
                  w_edge_cnt_nxt = w_edge_inc;
                  // Odd edges lead; the final trailing edge has no bit to shift out.
                  if (w_leading) begin
                     w_sample_stb_nxt = ~r_cpha;
                     w_shift_stb_nxt  = r_cpha;
                  end else begin
                     w_sample_stb_nxt = r_cpha;
                     w_shift_stb_nxt  = ~r_cpha & ~w_last_edge;
                     w_bit_idx_nxt    = r_bit_idx + NB_W'(1);
                  end
                  if (w_last_edge) begin
                     w_state_nxt   = ST_HOLD;
                     w_gap_cnt_nxt = {GAP_W{1'b0}};
                  end else begin
                     w_state_nxt = ST_RUN;
                  end
               end else begin
                  w_half_cnt_nxt = r_half_cnt + DIV_WIDTH'(1);
               end
            end
            ST_HOLD: begin
               if (r_gap_cnt == HOLD_LAST) begin
                  w_state_nxt   = ST_IDLE;
                  w_gap_cnt_nxt = {GAP_W{1'b0}};
                  w_cs_n_nxt    = 1'b1;
                  w_busy_nxt    = 1'b0;
                  w_done_nxt    = 1'b1;
               end else begin
                  w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cs_n_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_sclk_nxt  = r_cpol;
            end
         endcase
      end
   end

   // Configuration, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div        <= {DIV_WIDTH{1'b0}};
         r_cpol       <= 1'b0;
         r_cpha       <= 1'b0;
         r_nbits      <= {NB_W{1'b0}};
         r_half_cnt   <= {DIV_WIDTH{1'b0}};
         r_gap_cnt    <= {GAP_W{1'b0}};
         r_edge_cnt   <= {EDG_W{1'b0}};
         r_cs_n       <= 1'b1;
         r_sclk       <= 1'b0;
         r_sample_stb <= 1'b0;
         r_shift_stb  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_bit_idx    <= {NB_W{1'b0}};
      end else begin
         r_div        <= w_div_nxt;
         r_cpol       <= w_cpol_nxt;
         r_cpha       <= w_cpha_nxt;
         r_nbits      <= w_nbits_nxt;
         r_half_cnt   <= w_half_cnt_nxt;
         r_gap_cnt    <= w_gap_cnt_nxt;
         r_edge_cnt   <= w_edge_cnt_nxt;
         r_cs_n       <= w_cs_n_nxt;
         r_sclk       <= w_sclk_nxt;
         r_sample_stb <= w_sample_stb_nxt;
         r_shift_stb  <= w_shift_stb_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_bit_idx    <= w_bit_idx_nxt;
      end
   end

   assign bus.cs_n_o       = r_cs_n;
   assign bus.sclk_o       = r_sclk;
   assign bus.sample_stb_o = r_sample_stb;
   assign bus.shift_stb_o  = r_shift_stb;
   assign bus.busy_o       = r_busy;
   assign bus.done_o       = r_done;
   assign bus.bit_idx_o    = r_bit_idx;
endmodule
